// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit shifter.
package uart_tx_pkg;

    localparam int DATA_W = 8;
    localparam int WL_W   = 6;

    // 3-bit encoding kept identical to the comparator's view of the shifter state
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    function automatic int frame_bits(input bit parity_en);
        return parity_en ? 11 : 10;
    endfunction

endpackage

// File: rtl/uart_tx_shifter_if.sv
// PCI-side byte write channel into the transmit holding register.
interface uart_tx_shifter_if;
    import uart_tx_pkg::*;

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_tx_shifter_baud_gen.sv
// Free-running bit-period counter; tick marks the last cycle of each bit period.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_shifter.sv
// Holding register plus 8N1/8E1 frame shifter; workload reports unfinished frame bits.
module uart_tx_shifter
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_shifter_if.slave     wr,
    input  logic                 enable,
    output logic                 tx,
    output logic [WL_W-1:0]      workload,
    output logic                 busy
);

    localparam logic [WL_W-1:0] FRAME = WL_W'(frame_bits(PARITY_EN));

    tx_state_e         state;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    logic              parity;
    logic              load;
    logic              tick;

    assign load        = (state == IDLE) && hold_full && enable;
    assign wr.wr_ready = !hold_full;

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            workload  <= '0;
            busy      <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            parity    <= 1'b0;
        end else begin
            // a write needs an empty holder and a load a full one, so they never collide
            if (wr.wr_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= wr.wr_data;
            end

            if (load) begin
                state     <= START;
                tx        <= 1'b0;
                shreg     <= hold_data;
                parity    <= ^hold_data;
                hold_full <= 1'b0;
                workload  <= FRAME;
                busy      <= 1'b1;
                bit_cnt   <= '0;
            end else if (tick && state != IDLE) begin
                if (workload != '0) workload <= workload - 1'b1;
                case (state)
                    START: begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                                tx    <= parity;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    STOP: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
